// File: rtl/uart_sender.sv
// uart_sender: byte-wide FIFO front end feeding a UART transmitter.
//
// Frame format is 8N1: start bit (low), 8 data bits LSB first, one stop bit (high).
// With UART_SENDER_PARITY_EN defined, an even-parity bit is added between the
// data bits and the stop bit. The default build, with the macro undefined,
// produces 8N1 frames.
//
// Parameters
//   CLKS_PER_BIT : sysclk cycles per serial bit (5208 = 50 MHz / 9600 baud)
//   FIFO_DEPTH   : transmit FIFO entries; must be a power of two, >= 2
//
// Ports
//   sysclk     : single clock, all state updates on its rising edge
//   reset      : asynchronous active-low reset
//   tx_data    : byte to queue
//   tx_valid   : tx_data is offered this cycle
//   tx_ready   : FIFO can accept a byte this cycle
//   uart_tx    : registered serial line, idle high
//   tx_busy    : high while a frame is on the line or the FIFO is non-empty
//   fifo_count : queued bytes not yet loaded into the shifter
//   state_dbg  : current FSM state encoding (IDLE=0 START=1 DATA=2 STOP=3 PARITY=4)
//
// Handshake: a byte is written on a rising edge where tx_valid && tx_ready.
// tx_ready is decoded from the registered count only, so a full FIFO never
// accepts, even on a cycle where the transmitter pops a byte. tx_data is
// ignored on any cycle without acceptance.
module uart_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_SENDER_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t state, next_state;

  // FIFO storage and pointers
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          fifo_nonempty;

  // Transmit datapath
  logic [BW-1:0] baud_cnt;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          shift_en;
  logic          tx_next;
`ifdef UART_SENDER_PARITY_EN
  logic          parity_bit;
`endif

  assign fifo_nonempty = (fifo_count != '0);
  assign tx_ready      = (fifo_count != FULL);
  assign push          = tx_valid && tx_ready;
  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign tx_busy       = (state != S_IDLE) || fifo_nonempty;
  assign state_dbg     = state;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ------------------------------------------------------ FSM: state reg
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // ----------------------------------------------------- FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (fifo_nonempty) next_state = S_START;
      S_START: if (bit_end) next_state = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      end
`ifdef UART_SENDER_PARITY_EN
      S_PARITY: if (bit_end) next_state = S_STOP;
`endif
      S_STOP: begin
        // Back-to-back frames: go straight into the next start bit.
        if (bit_end) next_state = fifo_nonempty ? S_START : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------- FSM: outputs
  // tx_next is the line level for the cycle after the edge; it changes only
  // at bit boundaries, so the registered uart_tx holds each bit for exactly
  // CLKS_PER_BIT cycles.
  always_comb begin
    pop      = 1'b0;
    shift_en = 1'b0;
    tx_next  = uart_tx;
    case (state)
      S_IDLE: begin
        pop     = fifo_nonempty;
        tx_next = !fifo_nonempty;
      end
      S_START: begin
        if (bit_end) tx_next = shift_reg[0];
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
            tx_next = parity_bit;
`else
            tx_next = 1'b1;
`endif
          end else begin
            shift_en = 1'b1;
            tx_next  = shift_reg[1];
          end
        end
      end
`ifdef UART_SENDER_PARITY_EN
      S_PARITY: begin
        if (bit_end) tx_next = 1'b1;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          pop     = fifo_nonempty;
          tx_next = !fifo_nonempty;
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      uart_tx    <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
`ifdef UART_SENDER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      uart_tx <= tx_next;

      // Baud counter restarts at every bit boundary and sits at zero in IDLE,
      // so a frame launched from IDLE gets a full-length start bit.
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + BW'(1);

      if (state != S_DATA) bit_idx <= '0;
      else if (bit_end)    bit_idx <= bit_idx + 3'd1;

      // The shifter is only loaded on a pop, so later FIFO writes never touch
      // the frame in flight.
      if (pop) begin
        shift_reg  <= mem[rd_ptr];
`ifdef UART_SENDER_PARITY_EN
        parity_bit <= ^mem[rd_ptr];
`endif
      end else if (shift_en) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end
  end

endmodule
